// File: rtl/seed_sweep_ctrl.sv
// Seed sweep sequencer: fetches each seed from the seed RAM, walks the datapath through
// reset / inhibitor load / start, waits for the iteration target and streams one record per seed.
module seed_sweep_ctrl #(
    parameter int          STATE       = 32,
    parameter int          LOG_ITER    = 16,
    parameter int          LOG_RULES   = 8,
    parameter int          NUM_SEEDS   = 512,
    parameter int unsigned ITER_TARGET = 1000,
    parameter int          INHIBITOR   = 0,
    parameter int unsigned MAX_WAIT    = 2**20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic                 busy,
    output logic                 done,
    output logic                 seed_rd,
    output logic [9:0]           seed_addr,
    input  logic [63:0]          seed_data,
    output logic                 dp_rst_n,
    output logic                 dp_ld_inhibitor,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    output logic                 dp_start,
    output logic [63:0]          dp_seed,
    input  logic [STATE-1:0]     dp_network_state,
    input  logic                 dp_steady_state,
    input  logic [LOG_ITER-1:0]  dp_iteration_number,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [9:0]           res_idx,
    output logic [STATE-1:0]     res_state,
    output logic                 res_steady,
    output logic [LOG_ITER-1:0]  res_iters,
    output logic                 res_timeout
);

    typedef enum logic [3:0] {
        IDLE, FETCH, LATCH, RSTHI, LDINH, GAP1, START, GAP2, RUN, REPORT
    } state_e;

    localparam int                   WD_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(MAX_WAIT - 1);
    localparam logic [9:0]           LAST_IDX = 10'(NUM_SEEDS - 1);
    localparam logic [LOG_RULES-1:0] SEL_INH  = LOG_RULES'(~INHIBITOR);

    state_e               state_q, state_d;
    logic [9:0]           idx_q, idx_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 seed_rd_q, seed_rd_d;
    logic [9:0]           seed_addr_q, seed_addr_d;
    logic                 dp_rst_n_q, dp_rst_n_d;
    logic                 dp_ld_q, dp_ld_d;
    logic                 dp_start_q, dp_start_d;
    logic [63:0]          dp_seed_q, dp_seed_d;
    logic                 res_valid_q, res_valid_d;
    logic [9:0]           res_idx_q, res_idx_d;
    logic [STATE-1:0]     res_state_q, res_state_d;
    logic                 res_steady_q, res_steady_d;
    logic [LOG_ITER-1:0]  res_iters_q, res_iters_d;
    logic                 res_timeout_q, res_timeout_d;
    logic                 iter_hit, wd_hit;

    // Widen both sides so a target beyond the counter range simply never matches.
    assign iter_hit = 64'(dp_iteration_number) >= 64'(ITER_TARGET);
    assign wd_hit   = (wd_q == WD_LAST);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wd_d          = wd_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        dp_seed_d     = dp_seed_q;
        res_valid_d   = res_valid_q;
        res_idx_d     = res_idx_q;
        res_state_d   = res_state_q;
        res_steady_d  = res_steady_q;
        res_iters_d   = res_iters_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            IDLE: begin
                if (go) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                dp_seed_d = seed_data;
                state_d   = RSTHI;
            end
            RSTHI: state_d = LDINH;
            LDINH: state_d = GAP1;
            GAP1:  state_d = START;
            START: begin
                wd_d    = '0;
                state_d = GAP2;
            end
            GAP2:  state_d = RUN;
            RUN: begin
                wd_d = wd_hit ? wd_q : wd_q + 1'b1;
                if (iter_hit || wd_hit) begin
                    res_valid_d   = 1'b1;
                    res_idx_d     = idx_q;
                    res_state_d   = dp_network_state;
                    res_steady_d  = dp_steady_state;
                    res_iters_d   = dp_iteration_number;
                    res_timeout_d = wd_hit && !iter_hit;
                    state_d       = REPORT;
                end
            end
            REPORT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 10'd1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they come straight out of flops.
        seed_rd_d   = (state_d == FETCH);
        seed_addr_d = (state_d == FETCH) ? idx_d : seed_addr_q;
        dp_rst_n_d  = !(state_d inside {IDLE, FETCH, LATCH});
        dp_ld_d     = (state_d == LDINH);
        dp_start_d  = (state_d == START);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            wd_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            seed_rd_q     <= 1'b0;
            seed_addr_q   <= '0;
            dp_rst_n_q    <= 1'b0;
            dp_ld_q       <= 1'b0;
            dp_start_q    <= 1'b0;
            dp_seed_q     <= '0;
            res_valid_q   <= 1'b0;
            res_idx_q     <= '0;
            res_state_q   <= '0;
            res_steady_q  <= 1'b0;
            res_iters_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wd_q          <= wd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            seed_rd_q     <= seed_rd_d;
            seed_addr_q   <= seed_addr_d;
            dp_rst_n_q    <= dp_rst_n_d;
            dp_ld_q       <= dp_ld_d;
            dp_start_q    <= dp_start_d;
            dp_seed_q     <= dp_seed_d;
            res_valid_q   <= res_valid_d;
            res_idx_q     <= res_idx_d;
            res_state_q   <= res_state_d;
            res_steady_q  <= res_steady_d;
            res_iters_q   <= res_iters_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign seed_rd          = seed_rd_q;
    assign seed_addr        = seed_addr_q;
    assign dp_rst_n         = dp_rst_n_q;
    assign dp_ld_inhibitor  = dp_ld_q;
    assign dp_sel_inhibitor = SEL_INH;
    assign dp_start         = dp_start_q;
    assign dp_seed          = dp_seed_q;
    assign res_valid        = res_valid_q;
    assign res_idx          = res_idx_q;
    assign res_state        = res_state_q;
    assign res_steady       = res_steady_q;
    assign res_iters        = res_iters_q;
    assign res_timeout      = res_timeout_q;

endmodule

// File: tb/tb_seed_sweep_ctrl.sv
// Bench for seed_sweep_ctrl: two instances (iteration target 10 and 0) driven by seed RAM and
// datapath models; expected records queue up when a sweep is launched and are popped on handshake.
module tb_seed_sweep_ctrl;

    localparam int NS = 4;

    typedef struct packed {
        logic [9:0]  idx;
        logic [63:0] seed;
        logic [31:0] st;
        logic        steady;
        logic [15:0] iters;
        logic        tmo;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, go = 1'b0, go0 = 1'b0, res_ready = 1'b1, res_ready0 = 1'b1;
    logic        busy, done, seed_rd, dp_rst_n, dp_ld, dp_start, dp_steady, res_valid, res_steady, res_timeout;
    logic [9:0]  seed_addr, res_idx;
    logic [63:0] seed_data, dp_seed;
    logic [7:0]  dp_sel;
    logic [31:0] dp_state, res_state;
    logic [15:0] dp_iter, res_iters;
    logic        busy0, done0, seed_rd0, dp_rst_n0, dp_ld0, dp_start0, dp_steady0, res_valid0, res_steady0, res_timeout0;
    logic [9:0]  seed_addr0, res_idx0;
    logic [63:0] seed_data0, dp_seed0;
    logic [7:0]  dp_sel0;
    logic [31:0] dp_state0, res_state0;
    logic [15:0] dp_iter0, res_iters0;

    int   vectors = 0, miscompares = 0;
    int   done_cnt = 0, done0_cnt = 0;
    rec_t sb[$];
    logic stuck = 1'b0;
    logic [15:0] cnt = '0, cnt0 = '0;

    seed_sweep_ctrl #(.NUM_SEEDS(NS), .ITER_TARGET(10), .MAX_WAIT(64), .INHIBITOR(0)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
        .seed_rd(seed_rd), .seed_addr(seed_addr), .seed_data(seed_data),
        .dp_rst_n(dp_rst_n), .dp_ld_inhibitor(dp_ld), .dp_sel_inhibitor(dp_sel),
        .dp_start(dp_start), .dp_seed(dp_seed), .dp_network_state(dp_state),
        .dp_steady_state(dp_steady), .dp_iteration_number(dp_iter),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_state(res_state),
        .res_steady(res_steady), .res_iters(res_iters), .res_timeout(res_timeout));

    seed_sweep_ctrl #(.NUM_SEEDS(NS), .ITER_TARGET(0), .MAX_WAIT(64), .INHIBITOR(8'h5A)) dut0 (
        .clk(clk), .rst(rst), .go(go0), .busy(busy0), .done(done0),
        .seed_rd(seed_rd0), .seed_addr(seed_addr0), .seed_data(seed_data0),
        .dp_rst_n(dp_rst_n0), .dp_ld_inhibitor(dp_ld0), .dp_sel_inhibitor(dp_sel0),
        .dp_start(dp_start0), .dp_seed(dp_seed0), .dp_network_state(dp_state0),
        .dp_steady_state(dp_steady0), .dp_iteration_number(dp_iter0),
        .res_valid(res_valid0), .res_ready(res_ready0), .res_idx(res_idx0), .res_state(res_state0),
        .res_steady(res_steady0), .res_iters(res_iters0), .res_timeout(res_timeout0));

    // Seed RAM returns addr+1 one cycle after the read strobe; datapath counts after start.
    always @(posedge clk) begin
        if (seed_rd)  seed_data  <= 64'(seed_addr) + 64'd1;
        if (seed_rd0) seed_data0 <= 64'(seed_addr0) + 64'd1;
        if (!dp_rst_n) cnt <= '0;
        else if (!stuck && (dp_start || cnt != 16'd0)) cnt <= cnt + 16'd1;
        if (!dp_rst_n0) cnt0 <= '0;
        else cnt0 <= cnt0 + 16'd1;
        if (done)  done_cnt  <= done_cnt + 1;
        if (done0) done0_cnt <= done0_cnt + 1;
    end

    assign dp_iter    = cnt;
    assign dp_state   = dp_seed[31:0] ^ {16'hBEEF, cnt};
    assign dp_steady  = (cnt >= 16'd8);
    assign dp_iter0   = cnt0;
    assign dp_state0  = dp_seed0[31:0] ^ {16'hBEEF, cnt0};
    assign dp_steady0 = (cnt0 >= 16'd8);

    task automatic push_sweep(input logic stk, input logic [15:0] it);
        rec_t r;
        for (int i = 0; i < NS; i++) begin
            r.idx    = 10'(i);
            r.seed   = 64'(i + 1);
            r.iters  = it;
            r.st     = r.seed[31:0] ^ {16'hBEEF, it};
            r.steady = (it >= 16'd8);
            r.tmo    = stk;
            sb.push_back(r);
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_record(input int budget, output int waited, output bit got);
        got = 1'b0;
        waited = 0;
        while (!got && waited < budget) begin
            @(negedge clk);
            waited++;
            if (res_valid === 1'b1 && res_ready === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b1; go0 = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, seed_rd, dp_rst_n, dp_ld, dp_start, res_valid} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {busy, done, seed_rd, dp_rst_n, dp_ld, dp_start, res_valid});
        end
        vectors++;
        if ({seed_addr, dp_seed, res_idx, res_state, res_steady, res_iters, res_timeout} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected 0", {seed_addr, dp_seed, res_idx, res_state, res_steady, res_iters, res_timeout});
        end
        vectors++;
        if ({dp_sel, dp_sel0} !== 16'hFFA5) begin
            miscompares++;
            $display("[TB] FAIL sel_inhibitor: got %h expected ffa5", {dp_sel, dp_sel0});
        end
        rst = 1'b0; go = 1'b0; go0 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, seed_rd, busy0, seed_rd0} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL go_with_rst: got %b expected 0000", {busy, seed_rd, busy0, seed_rd0});
        end
    endtask

    task automatic test_sweep();
        logic [3:0] trace_exp [7] = '{4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1000, 4'b1010, 4'b1000};
        rec_t obs, exp;
        int w, d0;
        bit got;
        d0 = done_cnt;
        sb.delete();
        push_sweep(1'b0, 16'd10);
        pulse_go();
        vectors++;
        if ({busy, seed_addr} !== {1'b1, 10'd0}) begin
            miscompares++;
            $display("[TB] FAIL first_fetch: got %h expected 400", {busy, seed_addr});
        end
        for (int c = 1; c <= 7; c++) begin
            vectors++;
            if ({dp_rst_n, dp_ld, dp_start, seed_rd} !== trace_exp[c-1]) begin
                miscompares++;
                $display("[TB] FAIL trace_c%0d: got %b expected %b", c, {dp_rst_n, dp_ld, dp_start, seed_rd}, trace_exp[c-1]);
            end
            @(negedge clk);
        end
        for (int n = 0; n < NS; n++) begin
            wait_record(60, w, got);
            vectors++;
            if (!got || (n == 0 && w != 9)) begin
                miscompares++;
                $display("[TB] FAIL sweep_wait%0d: got waited=%0d found=%0d expected found=1", n, w, got);
            end
            obs = {res_idx, dp_seed, res_state, res_steady, res_iters, res_timeout};
            exp = (sb.size() != 0) ? sb.pop_front() : '1;
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("[TB] FAIL sweep_rec%0d: got %h expected %h", n, obs, exp);
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sweep_done: got pulses=%0d busy=%b expected pulses=1 busy=0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_backpressure();
        rec_t obs, exp;
        int w;
        bit got;
        sb.delete();
        push_sweep(1'b0, 16'd10);
        res_ready = 1'b0;
        pulse_go();
        w = 0;
        while (res_valid !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (res_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_valid: got %b expected 1", res_valid);
        end
        exp = sb[0];
        for (int k = 0; k < 20; k++) begin
            obs = {res_idx, dp_seed, res_state, res_steady, res_iters, res_timeout};
            vectors++;
            if ({obs, res_valid, seed_rd} !== {exp, 2'b10}) begin
                miscompares++;
                $display("[TB] FAIL bp_hold%0d: got %h expected %h", k, {obs, res_valid, seed_rd}, {exp, 2'b10});
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        void'(sb.pop_front());
        @(negedge clk);
        vectors++;
        if ({seed_rd, seed_addr, res_valid} !== {1'b1, 10'd1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got %h expected %h", {seed_rd, seed_addr, res_valid}, {1'b1, 10'd1, 1'b0});
        end
        for (int n = 1; n < NS; n++) begin
            wait_record(60, w, got);
            obs = {res_idx, dp_seed, res_state, res_steady, res_iters, res_timeout};
            exp = (sb.size() != 0) ? sb.pop_front() : '1;
            vectors++;
            if (!got || obs !== exp) begin
                miscompares++;
                $display("[TB] FAIL bp_rec%0d: got %h found=%0d expected %h", n, obs, got, exp);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        rec_t obs, exp;
        int w;
        bit got;
        sb.delete();
        push_sweep(1'b1, 16'd0);
        stuck = 1'b1;
        pulse_go();
        for (int n = 0; n < NS; n++) begin
            wait_record(100, w, got);
            vectors++;
            if (!got || (n == 0 && w != 71)) begin
                miscompares++;
                $display("[TB] FAIL tmo_wait%0d: got waited=%0d found=%0d expected waited=71 found=1", n, w, got);
            end
            obs = {res_idx, dp_seed, res_state, res_steady, res_iters, res_timeout};
            exp = (sb.size() != 0) ? sb.pop_front() : '1;
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("[TB] FAIL tmo_rec%0d: got %h expected %h", n, obs, exp);
            end
        end
        stuck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        rec_t obs, exp;
        int w, d0;
        bit got;
        sb.delete();
        push_sweep(1'b0, 16'd10);
        pulse_go();
        for (int n = 0; n < 2; n++) begin
            wait_record(60, w, got);
            obs = {res_idx, dp_seed, res_state, res_steady, res_iters, res_timeout};
            exp = (sb.size() != 0) ? sb.pop_front() : '1;
            vectors++;
            if (!got || obs !== exp) begin
                miscompares++;
                $display("[TB] FAIL pre_rst_rec%0d: got %h found=%0d expected %h", n, obs, got, exp);
            end
        end
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, seed_rd, dp_rst_n, dp_ld, dp_start, res_valid, seed_addr, dp_seed,
             res_idx, res_state, res_steady, res_iters, res_timeout} !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_rst: got %h expected 0", {busy, done, seed_rd, dp_rst_n, dp_ld, dp_start, res_valid,
                     seed_addr, dp_seed, res_idx, res_state, res_steady, res_iters, res_timeout});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt != d0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_quiet: got pulses=%0d valid=%b expected pulses=0 valid=0", done_cnt - d0, res_valid);
        end
        sb.delete();
        push_sweep(1'b0, 16'd10);
        pulse_go();
        for (int n = 0; n < NS; n++) begin
            wait_record(60, w, got);
            obs = {res_idx, dp_seed, res_state, res_steady, res_iters, res_timeout};
            exp = (sb.size() != 0) ? sb.pop_front() : '1;
            vectors++;
            if (!got || obs !== exp) begin
                miscompares++;
                $display("[TB] FAIL restart_rec%0d: got %h found=%0d expected %h", n, obs, got, exp);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_go_ignored();
        rec_t obs, exp;
        int recs, k, d0;
        bit extra;
        sb.delete();
        push_sweep(1'b0, 16'd5);
        d0 = done0_cnt;
        go0 = 1'b1;
        @(negedge clk);
        go0 = 1'b0;
        recs = 0;
        k = 0;
        while (recs < NS && k < 200) begin
            go0 = 1'b0;
            if (res_valid0 === 1'b1 && res_ready0 === 1'b1) begin
                obs = {res_idx0, dp_seed0, res_state0, res_steady0, res_iters0, res_timeout0};
                exp = (sb.size() != 0) ? sb.pop_front() : '1;
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL t0_rec%0d: got %h expected %h", recs, obs, exp);
                end
                recs++;
                if (recs == NS) go0 = 1'b1;
            end else if (k % 5 == 2) begin
                go0 = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        go0 = 1'b0;
        vectors++;
        if (recs != NS) begin
            miscompares++;
            $display("[TB] FAIL t0_count: got %0d expected %0d", recs, NS);
        end
        extra = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (busy0 !== 1'b0 || seed_rd0 !== 1'b0 || res_valid0 !== 1'b0) extra = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (extra || done0_cnt - d0 != 1) begin
            miscompares++;
            $display("[TB] FAIL t0_idle: got restarted=%b pulses=%0d expected restarted=0 pulses=1", extra, done0_cnt - d0);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation bound expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_sweep();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        test_go_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
